// File: rtl/aes_sched_pkg.sv
// Shared widths and FSM encoding for the AES-128 request scheduler.
// Build option: AES_CBC_CHAIN_EN enables per-requester CBC chaining.
package aes_sched_pkg;

  localparam int AES_BLK_W = 128;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/AES_128_Encryptor.sv
// Fully combinational AES-128 block encryptor (FIPS-197 byte order).
// Build option: none; the S-box is derived from the GF(2^8) inverse.
module AES_128_Encryptor
  import aes_sched_pkg::*;
(
  input  logic [AES_BLK_W-1:0] in,
  input  logic [AES_BLK_W-1:0] key,
  output logic [AES_BLK_W-1:0] cipher
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt,
                                       input logic [127:0] k);
    logic [127:0] st;
    logic [127:0] rk;
    logic [31:0]  t;
    logic [7:0]   rc;
    rk = k;
    st = pt ^ rk;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t  = {rk[23:0], rk[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]),
            sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ t;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = xt(rc);
      st = sub_shift(st);
      if (r != 10) st = mix(st);
      st = st ^ rk;
    end
    return st;
  endfunction

  assign cipher = enc(in, key);

endmodule

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; the loser of the previous grant wins a tie.
// Build option: none (AES_CBC_CHAIN_EN lives in the scheduler top).
module aes_rr_arb2
  import aes_sched_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_id_o = 1'b0;
    if (&valid_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      gnt_id_o = 1'b1;
    end
    gnt_o = '0;
    if (en_i && (|valid_i)) begin
      gnt_o[gnt_id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_128_enc_scheduler.sv
// Round-robin scheduler sharing one multicycle AES-128 engine between two ports.
// Build option: AES_CBC_CHAIN_EN adds per-requester CBC chain registers.
module aes_128_enc_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [AES_BLK_W-1:0] req_data0,
  input  logic [AES_BLK_W-1:0] req_key0,
  input  logic [AES_BLK_W-1:0] req_data1,
  input  logic [AES_BLK_W-1:0] req_key1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic                 rsp_id,
  output logic                 busy
`ifdef AES_CBC_CHAIN_EN
  ,
  input  logic [1:0]           chain_clr
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] eng_in_q, eng_in_d;
  logic [AES_BLK_W-1:0] eng_key_q, eng_key_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 busy_q, busy_d;

  logic [1:0]           gnt;
  logic                 gnt_id;
  logic                 accept;
  logic                 capture;
  logic [AES_BLK_W-1:0] sel_data, sel_key, blk_in;
  logic [AES_BLK_W-1:0] cipher;

  aes_rr_arb2 u_arb (
    .en_i         (state_q == ST_IDLE),
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .gnt_id_o     (gnt_id)
  );

  AES_128_Encryptor u_aes (
    .in     (eng_in_q),
    .key    (eng_key_q),
    .cipher (cipher)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign capture   = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
  assign sel_data  = gnt_id ? req_data1 : req_data0;
  assign sel_key   = gnt_id ? req_key1 : req_key0;

`ifdef AES_CBC_CHAIN_EN
  logic [1:0][AES_BLK_W-1:0] chain_q, chain_d;

  // a clear on the same edge as a capture wins
  always_comb begin
    chain_d = chain_q;
    if (capture) chain_d[rsp_id_q] = cipher;
    for (int i = 0; i < 2; i++) begin
      if (chain_clr[i]) chain_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign blk_in = sel_data ^ chain_q[gnt_id];
`else
  assign blk_in = sel_data;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    eng_in_d     = eng_in_q;
    eng_key_d    = eng_key_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          eng_in_d     = blk_in;
          eng_key_d    = sel_key;
          rsp_id_d     = gnt_id;
          last_grant_d = gnt_id;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (capture) begin
          rsp_data_d  = cipher;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      eng_in_q     <= '0;
      eng_key_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      eng_in_q     <= eng_in_d;
      eng_key_q    <= eng_key_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_128_enc_scheduler.sv
// Directed scoreboard bench for aes_128_enc_scheduler (SETTLE 4 and SETTLE 1).
// Build option: AES_CBC_CHAIN_EN adds the chaining sequence.
`timescale 1ns/1ps
module tb_aes_128_enc_scheduler;

  localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ZZ = 128'hf795bd4a52e29ed713d313fa20e98dbc;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [127:0] d0 = P0, k0 = K0, d1 = P1, k1 = K1;
  logic         rsp_valid, rsp_id, busy;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic [1:0]   f_valid = 2'b00;
  logic [1:0]   f_ready;
  logic         f_rsp_valid, f_rsp_id, f_busy;
  logic [127:0] f_rsp_data;
  logic [1:0]   clr = 2'b11;

  int           checks = 0;
  int           failures = 0;
  int           n_rsp = 0;
  logic         m_last = 1'b1;
  logic [127:0] exp0 = C0;
  logic [127:0] exp1 = C1;
  exp_t         sb_q[$];

  always #5 clk = ~clk;

  aes_128_enc_scheduler #(.SETTLE_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (d0),
    .req_key0  (k0),
    .req_data1 (d1),
    .req_key1  (k1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef AES_CBC_CHAIN_EN
    ,
    .chain_clr (clr)
`endif
  );

  aes_128_enc_scheduler #(.SETTLE_CYCLES(1)) u_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (f_valid),
    .req_ready (f_ready),
    .req_data0 (P0),
    .req_key0  (K0),
    .req_data1 (P1),
    .req_key1  (K1),
    .rsp_valid (f_rsp_valid),
    .rsp_ready (1'b1),
    .rsp_data  (f_rsp_data),
    .rsp_id    (f_rsp_id),
    .busy      (f_busy)
`ifdef AES_CBC_CHAIN_EN
    ,
    .chain_clr (2'b11)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id);
    exp_t e;
    e.id   = id;
    e.data = id ? exp1 : exp0;
    sb_q.push_back(e);
  endtask

  // model the round-robin order, then drive and retire each request
  task automatic send(input logic [1:0] mask);
    logic q[$];
    logic [1:0] acc;
    int n;
    if (mask == 2'b11) begin
      q.push_back(~m_last);
      q.push_back(m_last);
    end else begin
      q.push_back(mask[1]);
    end
    m_last = q[$];
    foreach (q[i]) push(q[i]);
    req_valid = mask;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        chk("accept_order", acc, 2'b01 << q[0]);
        void'(q.pop_front());
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
      end
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout observed=%0d pending expected=0", q.size());
      req_valid = 2'b00;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL rsp_unexpected observed=%h expected=none", rsp_data);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    int n0, last, nacc, n;

    // reset state
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: FIPS-197 vector and latency
    send(2'b01);
    chk("t1_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_early", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, C0);
    rsp_ready = 1'b1;
    drain();

    // T2: simultaneous requests, twice
    send(2'b11);
    drain();
    send(2'b11);
    drain();

    // T3: backpressure in DONE
    rsp_ready = 1'b0;
    send(2'b01);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n0 = n_rsp;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, C0);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", req_ready, 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain();
    chk("bp_count", n_rsp - n0, 1);

    // T4: reset at cnt=2 drops the block
    send(2'b10);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    void'(sb_q.pop_back());
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_rsp;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", n_rsp - n0, 0);
    send(2'b11);
    drain();

    // T5: SETTLE_CYCLES=1 back-to-back throughput
    f_valid = 2'b01;
    last = -1;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|(f_valid & f_ready)) begin
        if (last >= 0) chk("fast_period", c - last, 3);
        last = c;
        nacc++;
      end
      if (f_rsp_valid) chk("fast_rsp", f_rsp_data, C0);
    end
    f_valid = 2'b00;
    chk("fast_accepts", nacc, 7);

`ifdef AES_CBC_CHAIN_EN
    // T6: CBC chaining on requester 0
    d0 = '0;
    k0 = '0;
    clr = 2'b00;
    exp0 = ZC;
    send(2'b01);
    drain();
    exp0 = ZZ;
    send(2'b01);
    drain();
    clr = 2'b01;
    @(posedge clk);
    #1;
    clr = 2'b00;
    exp0 = ZC;
    send(2'b01);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
